// File: rtl/l1_dcache_pkg.sv
// -----------------------------------------------------------------------------
// cache_types
//   Shared geometry, typedefs and helpers for the two-way L1 data cache.
//   32-bit byte address split: tag [31:8], index [7:5], word [4:2].
// -----------------------------------------------------------------------------
package cache_types;

    localparam int S_INDEX    = 3;
    localparam int S_OFFSET   = 5;
    localparam int S_TAG      = 32 - S_INDEX - S_OFFSET;
    localparam int NUM_SETS   = 1 << S_INDEX;
    localparam int LINE_BYTES = 1 << S_OFFSET;
    localparam int LINE_BITS  = 8 * LINE_BYTES;
    localparam int WORD_BITS  = S_OFFSET - 2;

    typedef logic [S_TAG-1:0]      dc_tag_t;
    typedef logic [S_INDEX-1:0]    dc_index_t;
    typedef logic [LINE_BITS-1:0]  dc_line_t;
    typedef logic [LINE_BYTES-1:0] dc_bmask_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } dcache_state_t;

    // Byte enables for a 32-bit store landing in word slot 'word' of a line.
    function automatic dc_bmask_t word_byte_en(input logic [WORD_BITS-1:0] word,
                                               input logic [3:0]           wmask);
        dc_bmask_t en;
        en = '0;
        en[{word, 2'b00} +: 4] = wmask;
        return en;
    endfunction

endpackage

// File: rtl/l1_dcache_way.sv
// -----------------------------------------------------------------------------
// dcache_way
//   One way of the data cache: per-set valid, dirty, tag and 256-bit line.
//   All reads are asynchronous on i_index; writes happen on the rising edge.
//
//   clk, rst_n      clock, asynchronous active-low reset (valid/dirty only)
//   i_index         set being read and written
//   o_valid/o_dirty/o_tag/o_data   contents of the addressed set
//   i_set_valid     mark the set valid
//   i_load_dirty    load i_dirty into the set's dirty bit
//   i_load_tag      load i_tag into the set's tag
//   i_byte_en       per-byte write enable into the line, data from i_data
// -----------------------------------------------------------------------------
module dcache_way
    import cache_types::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [S_INDEX-1:0]    i_index,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [S_TAG-1:0]      o_tag,
    output logic [LINE_BITS-1:0]  o_data,
    input  logic                  i_set_valid,
    input  logic                  i_load_dirty,
    input  logic                  i_dirty,
    input  logic                  i_load_tag,
    input  logic [S_TAG-1:0]      i_tag,
    input  logic [LINE_BYTES-1:0] i_byte_en,
    input  logic [LINE_BITS-1:0]  i_data
);

    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    dc_tag_t             r_tag  [NUM_SETS];
    dc_line_t            r_data [NUM_SETS];

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_set_valid) begin
                r_valid[i_index] <= 1'b1;
            end
            if (i_load_dirty) begin
                r_dirty[i_index] <= i_dirty;
            end
        end
    end

    // NOTE: tag and data storage has no reset on purpose; the valid bits
    // already make stale contents unreachable, and leaving the arrays
    // reset-free lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_load_tag) begin
            r_tag[i_index] <= i_tag;
        end
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (i_byte_en[b]) begin
                r_data[i_index][8*b +: 8] <= i_data[8*b +: 8];
            end
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

endmodule

// File: rtl/l1_dcache.sv
// -----------------------------------------------------------------------------
// l1_dcache
//   Two-way set-associative, write-back, write-allocate L1 data cache.
//   CPU side: 32-bit loads/stores held until the one-cycle mem_resp pulse.
//   Memory side: 256-bit line fill (pmem_read) and victim writeback
//   (pmem_write), each held until pmem_resp.
//
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_read/mem_write          CPU request (write wins if both are high)
//   mem_wmask/mem_wdata         store byte enables / lane-aligned data
//   mem_address                 byte address, bits [1:0] ignored
//   mem_rdata/mem_resp          load data / completion pulse
//   pmem_read/pmem_write        fill / writeback request
//   pmem_address/pmem_wdata     line address / victim line
//   pmem_rdata/pmem_resp        fill data / memory completion
// -----------------------------------------------------------------------------
module l1_dcache
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_wmask,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    dcache_state_t       r_state;
    dcache_state_t       w_next_state;
    logic [NUM_SETS-1:0] r_lru;      // per set: way to evict next
    logic                r_victim;   // way chosen on the last miss

    dc_tag_t              w_tag;
    dc_index_t            w_index;
    logic [WORD_BITS-1:0] w_word;
    logic                 w_unused_addr;

    assign w_tag         = mem_address[31 -: S_TAG];
    assign w_index       = mem_address[S_OFFSET +: S_INDEX];
    assign w_word        = mem_address[S_OFFSET-1:2];
    assign w_unused_addr = ^mem_address[1:0];

    // Per-way read ports and write controls
    logic [1:0] w_valid;
    logic [1:0] w_dirty;
    dc_tag_t    w_way_tag  [2];
    dc_line_t   w_way_data [2];
    logic [1:0] w_set_valid;
    logic [1:0] w_load_dirty;
    logic [1:0] w_dirty_in;
    logic [1:0] w_load_tag;
    dc_bmask_t  w_byte_en  [2];
    dc_line_t   w_wline;

    logic [1:0] w_hit;
    logic       w_hit_any;
    logic       w_hit_way;
    logic       w_miss_victim;

    for (genvar g = 0; g < 2; g++) begin : g_way
        dcache_way u_way (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_index      (w_index),
            .o_valid      (w_valid[g]),
            .o_dirty      (w_dirty[g]),
            .o_tag        (w_way_tag[g]),
            .o_data       (w_way_data[g]),
            .i_set_valid  (w_set_valid[g]),
            .i_load_dirty (w_load_dirty[g]),
            .i_dirty      (w_dirty_in[g]),
            .i_load_tag   (w_load_tag[g]),
            .i_tag        (w_tag),
            .i_byte_en    (w_byte_en[g]),
            .i_data       (w_wline)
        );

        assign w_hit[g] = w_valid[g] && (w_way_tag[g] == w_tag);
    end

    assign w_hit_any = |w_hit;
    assign w_hit_way = ~w_hit[0];

    // Fill an invalid way first (way 0 preferred); only evict when both are live.
    assign w_miss_victim = !w_valid[0] ? 1'b0 :
                           !w_valid[1] ? 1'b1 : r_lru[w_index];

    // The only line-wide write is the fill; stores replicate the word so the
    // byte enables pick the right lane.
    assign w_wline = (r_state == ALLOCATE) ? pmem_rdata : {(LINE_BITS/32){mem_wdata}};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_set_valid  = '0;
        w_load_dirty = '0;
        w_dirty_in   = '0;
        w_load_tag   = '0;
        w_byte_en[0] = '0;
        w_byte_en[1] = '0;

        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_next_state = COMPARE;
                end
            end

            COMPARE: begin
                if (w_hit_any) begin
                    w_next_state = IDLE;
                    if (mem_write) begin
                        w_byte_en[w_hit_way]    = word_byte_en(w_word, mem_wmask);
                        w_load_dirty[w_hit_way] = 1'b1;
                        w_dirty_in[w_hit_way]   = 1'b1;
                    end
                end else if (w_valid[w_miss_victim] && w_dirty[w_miss_victim]) begin
                    w_next_state = WRITEBACK;
                end else begin
                    w_next_state = ALLOCATE;
                end
            end

            WRITEBACK: begin
                if (pmem_resp) begin
                    w_load_dirty[r_victim] = 1'b1;
                    w_next_state           = ALLOCATE;
                end
            end

            ALLOCATE: begin
                if (pmem_resp) begin
                    w_byte_en[r_victim]    = '1;
                    w_load_tag[r_victim]   = 1'b1;
                    w_set_valid[r_victim]  = 1'b1;
                    w_load_dirty[r_victim] = 1'b1;
                    w_next_state           = COMPARE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_lru    <= '0;
            r_victim <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == COMPARE) begin
                if (w_hit_any) begin
                    r_lru[w_index] <= ~w_hit_way;
                end else begin
                    // Latched so WRITEBACK/ALLOCATE keep targeting the same way
                    // even as the dirty bit changes under them.
                    r_victim <= w_miss_victim;
                end
            end
        end
    end

    // All outputs decode from state, so an async reset clears them at once.
    assign mem_resp   = (r_state == COMPARE) && w_hit_any;
    assign mem_rdata  = mem_resp ? w_way_data[w_hit_way][{w_word, 5'b0} +: 32] : 32'h0;
    assign pmem_read  = (r_state == ALLOCATE);
    assign pmem_write = (r_state == WRITEBACK);
    assign pmem_wdata = (r_state == WRITEBACK) ? w_way_data[r_victim] : '0;

    always_comb begin
        case (r_state)
            WRITEBACK: pmem_address = {w_way_tag[r_victim], w_index, {S_OFFSET{1'b0}}};
            ALLOCATE:  pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
            default:   pmem_address = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_l1_dcache.sv
// -----------------------------------------------------------------------------
// tb_l1_dcache
//   Directed bench for l1_dcache. A golden word-level memory supplies the
//   expected load data, pushed to a scoreboard queue when a request is driven
//   and popped when mem_resp arrives. A responder process models physical
//   memory and logs every pmem transaction for later inspection.
// -----------------------------------------------------------------------------
module tb_l1_dcache;
    import cache_types::*;

    localparam int MEM_LAT = 2;
    localparam int TIMEOUT = 200;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_wmask;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    l1_dcache dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        dc_line_t    data;
        int          start_cyc;
        int          resp_cyc;
    } pmem_ev_t;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    pmem_ev_t    ev_log[$];
    exp_t        exp_q[$];
    dc_line_t    mem_model [logic [31:0]];
    logic [31:0] gold      [logic [31:0]];

    int   checks        = 0;
    int   errors        = 0;
    logic mem_hold      = 1'b0;
    logic both_seen     = 1'b0;
    int   last_lat      = 0;
    int   last_resp_cyc = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input dc_line_t obs, input dc_line_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- golden memory ----------------
    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (gold.exists(k)) return gold[k];
        return 32'h0;
    endfunction

    function automatic dc_line_t gold_line(input logic [31:0] a);
        dc_line_t    l;
        logic [31:0] base;
        base = {a[31:5], 5'b0};
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_word(base + 32'(4*w));
        return l;
    endfunction

    function automatic dc_line_t mem_line(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:5], 5'b0};
        if (mem_model.exists(k)) return mem_model[k];
        return '0;
    endfunction

    task automatic set_mem_word(input logic [31:0] a, input logic [31:0] d);
        dc_line_t    l;
        logic [31:0] k;
        k = {a[31:5], 5'b0};
        l = mem_line(a);
        l[int'(a[4:2])*32 +: 32] = d;
        mem_model[k] = l;
        gold[{a[31:2], 2'b00}] = d;
    endtask

    task automatic preload_line(input logic [31:0] base, input logic [31:0] seed);
        for (int w = 0; w < 8; w++) set_mem_word(base + 32'(4*w), seed + 32'(w));
    endtask

    // ---------------- physical memory responder ----------------
    initial begin
        pmem_ev_t ev;
        int       lat_cnt;
        int       start;
        lat_cnt    = 0;
        start      = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if ((pmem_read || pmem_write) && !mem_hold) begin
                if (lat_cnt == 0) start = cyc;
                if (lat_cnt == MEM_LAT) begin
                    ev.is_write  = pmem_write;
                    ev.addr      = pmem_address;
                    ev.start_cyc = start;
                    ev.resp_cyc  = cyc;
                    if (pmem_write) begin
                        ev.data = pmem_wdata;
                        mem_model[pmem_address] = pmem_wdata;
                    end else begin
                        ev.data    = mem_line(pmem_address);
                        pmem_rdata = ev.data;
                    end
                    ev_log.push_back(ev);
                    pmem_resp = 1'b1;
                    lat_cnt   = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // ---------------- CPU side ----------------
    // Entered and left just after a rising edge.
    task automatic cpu_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [3:0] wmask,
                              input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] g;
        int          waited;
        e.is_read = rd && !wr;
        e.data    = gold_word(addr);
        if (wr) begin
            g = gold_word(addr);
            for (int b = 0; b < 4; b++) if (wmask[b]) g[8*b +: 8] = wdata[8*b +: 8];
            gold[{addr[31:2], 2'b00}] = g;
        end
        exp_q.push_back(e);

        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wmask   = wmask;
        mem_wdata   = wdata;

        waited = 0;
        while (1) begin
            @(negedge clk);
            waited++;
            if (mem_resp || waited >= TIMEOUT) break;
        end
        check({tag, "_resp"}, 32'(mem_resp), 32'd1);
        e = exp_q.pop_front();
        if (mem_resp && e.is_read) check({tag, "_rdata"}, mem_rdata, e.data);
        last_lat      = waited - 1;
        last_resp_cyc = cyc;

        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int       n;
        int       waited;
        pmem_ev_t ev;
        pmem_ev_t ev2;

        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = 4'h0;
        mem_address = 32'h0;
        mem_wdata   = 32'h0;

        preload_line(32'h0000_0040, 32'h1000_0000);
        set_mem_word(32'h0000_0044, 32'hDEAD_BEEF);
        preload_line(32'h0002_0040, 32'h2000_0000);
        preload_line(32'h0003_0040, 32'h3000_0000);
        preload_line(32'h0001_00A0, 32'hA100_0000);
        preload_line(32'h0002_00A0, 32'hA200_0000);
        preload_line(32'h0003_00A0, 32'hA300_0000);
        preload_line(32'h0004_0060, 32'h4000_0000);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_resp",   32'(mem_resp), 32'd0);
        check("rst_pmem_read",  32'(pmem_read), 32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_pmem_addr",  pmem_address, 32'h0);
        check("rst_mem_rdata",  mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold miss then hit in the filled line
        n = ev_log.size();
        cpu_access("cold_rd40", 1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
        check("cold_ev_cnt", 32'(ev_log.size()), 32'(n + 1));
        ev = ev_log[n];
        check("cold_ev_rd",   32'(ev.is_write), 32'd0);
        check("cold_ev_addr", ev.addr, 32'h0000_0040);
        check("cold_miss_lat", 32'((last_resp_cyc - ev.resp_cyc) >= 1 &&
                                   (last_resp_cyc - ev.resp_cyc) <= 2), 32'd1);
        cpu_access("hit_rd44", 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0);
        check("hit_rd44_lat", last_lat, 32'd1);
        check("hit_no_pmem", 32'(ev_log.size()), 32'(n + 1));

        // Hit write with partial mask, then read back
        cpu_access("hit_wr44", 1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'h0000_1234);
        check("hit_wr44_lat", last_lat, 32'd1);
        cpu_access("hit_rd44b", 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0);
        check("hit_rd44b_lat", last_lat, 32'd1);
        check("hit_wr_no_pmem", 32'(ev_log.size()), 32'(n + 1));

        // Dirty conflict eviction in set 2: A=0x40 (dirty), B, then C
        cpu_access("cf_rdB",  1'b1, 1'b0, 32'h0002_0044, 4'h0, 32'h0);
        cpu_access("cf_rdB2", 1'b1, 1'b0, 32'h0002_0048, 4'h0, 32'h0);
        n = ev_log.size();
        cpu_access("cf_rdC",  1'b1, 1'b0, 32'h0003_004C, 4'h0, 32'h0);
        check("cf_ev_cnt", 32'(ev_log.size()), 32'(n + 2));
        ev  = ev_log[n];
        ev2 = ev_log[n + 1];
        check("cf_wb_is_wr", 32'(ev.is_write), 32'd1);
        check("cf_wb_addr",  ev.addr, 32'h0000_0040);
        check_line("cf_wb_data", ev.data, gold_line(32'h0000_0040));
        check("cf_fill_is_rd", 32'(ev2.is_write), 32'd0);
        check("cf_fill_addr",  ev2.addr, 32'h0003_0040);
        check("cf_fill_follows_wb", ev2.start_cyc, ev.resp_cyc + 1);
        n = ev_log.size();
        cpu_access("cf_rdB3", 1'b1, 1'b0, 32'h0002_0040, 4'h0, 32'h0);
        check("cf_B_resident", 32'(ev_log.size()), 32'(n));
        check("cf_B_lat", last_lat, 32'd1);

        // Clean conflict eviction in set 5
        cpu_access("cl_rdA",  1'b1, 1'b0, 32'h0001_00A0, 4'h0, 32'h0);
        cpu_access("cl_rdB",  1'b1, 1'b0, 32'h0002_00A4, 4'h0, 32'h0);
        cpu_access("cl_rdB2", 1'b1, 1'b0, 32'h0002_00A8, 4'h0, 32'h0);
        n = ev_log.size();
        cpu_access("cl_rdC",  1'b1, 1'b0, 32'h0003_00AC, 4'h0, 32'h0);
        check("cl_ev_cnt", 32'(ev_log.size()), 32'(n + 1));
        ev = ev_log[n];
        check("cl_fill_is_rd", 32'(ev.is_write), 32'd0);
        check("cl_fill_addr",  ev.addr, 32'h0003_00A0);
        n = ev_log.size();
        cpu_access("cl_rdB3", 1'b1, 1'b0, 32'h0002_00A0, 4'h0, 32'h0);
        check("cl_B_resident", 32'(ev_log.size()), 32'(n));

        // Reset in the middle of a fill
        mem_hold    = 1'b1;
        n           = ev_log.size();
        mem_read    = 1'b1;
        mem_address = 32'h0004_0060;
        waited      = 0;
        while (!pmem_read && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check("mr_fill_started", 32'(pmem_read), 32'd1);
        check("mr_fill_addr", pmem_address, 32'h0004_0060);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_pmem_read_drop", 32'(pmem_read), 32'd0);
        check("mr_pmem_addr_zero", pmem_address, 32'h0);
        check("mr_mem_resp_zero",  32'(mem_resp), 32'd0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        check("mr_no_ev", 32'(ev_log.size()), 32'(n));
        cpu_access("mr_rd60", 1'b1, 1'b0, 32'h0004_0060, 4'h0, 32'h0);
        check("mr_refill_cnt", 32'(ev_log.size()), 32'(n + 1));
        ev = ev_log[n];
        check("mr_refill_addr", ev.addr, 32'h0004_0060);
        n = ev_log.size();
        cpu_access("mr_rd44", 1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0);
        check("mr_44_refetched", 32'(ev_log.size()), 32'(n + 1));

        // Read and write together: the write is performed
        cpu_access("rw_both", 1'b1, 1'b1, 32'h0004_0064, 4'hF, 32'hCAFE_F00D);
        @(negedge clk);
        check("rw_resp_single", 32'(mem_resp), 32'd0);
        @(posedge clk);
        #1;
        cpu_access("rw_rdback", 1'b1, 1'b0, 32'h0004_0064, 4'h0, 32'h0);

        check("never_rd_and_wr", 32'(both_seen), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
